sa_col_ctrl: RTL and testbench

//  Parametrised output-stationary systolic-array column with its own sequencing FSM.
//  - Weights enter at row 0 and ripple down one row per cycle; each row has its own data lane.
//  - Each PE multiply-accumulates locally over k_len beats.
//  - Accumulators then drain serially over a valid/ready port.
//  - Data lanes are re-registered for the next column; the last row's weight/valid feed cascaded columns.

---
 rtl/sa_pkg.sv | 17 +
 rtl/sa_col_ctrl_if.sv | 34 +++
 rtl/sa_pe_acc.sv | 53 +++++
 rtl/sa_col_ctrl.sv | 85 ++++++++
 tb/tb_sa_col_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, default widths and the saturating adder for the systolic column.
package sa_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DRAIN} state_t;
    localparam int ROWS_D   = 4;
    localparam int DATA_W_D = 8;
    localparam int WGT_W_D  = 8;
    localparam int ACC_W_D  = 32;
    localparam int CNT_W_D  = 16;
    // Clamps a+b to the signed range of a w-bit accumulator (w <= 63).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        logic signed [64:0] s, hi, lo;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        return s > hi ? hi[63:0] : s < lo ? lo[63:0] : s[63:0];
    endfunction
endpackage

// File: rtl/sa_col_ctrl_if.sv
// sa_col_ctrl_if: job control, weight stream, data lanes and result drain of one systolic column.
interface sa_col_ctrl_if #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
);
    logic                   start;
    logic [CNT_W-1:0]       k_len;
    logic                   busy;
    logic                   done;
    logic                   w_valid;
    logic [WGT_W-1:0]       w_in;
    logic                   w_ready;
    logic [ROWS*DATA_W-1:0] data_in;
    logic [ROWS*DATA_W-1:0] data_out;
    logic                   w_valid_out;
    logic [WGT_W-1:0]       w_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [ACC_W-1:0]       res_data;
    logic                   res_last;
    logic [ROWS*ACC_W-1:0]  result_bus;
    logic [ROWS-1:0]        sat_flags;
    modport master (
        output start, k_len, w_valid, w_in, data_in, res_ready,
        input  busy, done, w_ready, data_out, w_valid_out, w_out, res_valid, res_data, res_last, result_bus, sat_flags
    );
    modport slave (
        input  start, k_len, w_valid, w_in, data_in, res_ready,
        output busy, done, w_ready, data_out, w_valid_out, w_out, res_valid, res_data, res_last, result_bus, sat_flags
    );
endinterface

// File: rtl/sa_pe_acc.sv
// sa_pe_acc: one column PE -- weight/valid pipeline stage, signed MAC and accumulator.
// With SA_COL_SAT_EN defined the accumulator saturates and raises a sticky flag; otherwise it wraps.
module sa_pe_acc
    import sa_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int WGT_W  = WGT_W_D,
    parameter int ACC_W  = ACC_W_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wv_in,
    input  logic [WGT_W-1:0]  w_in,
    input  logic [DATA_W-1:0] lane,
    output logic              wv,
    output logic [WGT_W-1:0]  w,
    output logic [ACC_W-1:0]  acc,
    output logic              sat
);
    logic signed [DATA_W+WGT_W-1:0] prod;
    logic [ACC_W-1:0] acc_nx;
    logic clamp;
    assign prod = $signed(lane) * $signed(w);
`ifdef SA_COL_SAT_EN
    logic signed [63:0] a64, p64;
    assign a64    = 64'(signed'(acc));
    assign p64    = 64'(prod);
    assign acc_nx = (ACC_W)'(sat_add(a64, p64, ACC_W));
    assign clamp  = sat_add(a64, p64, ACC_W) != a64 + p64;
`else
    assign acc_nx = acc + (ACC_W)'(prod);
    assign clamp  = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv  <= 1'b0;
            w   <= '0;
            acc <= '0;
            sat <= 1'b0;
        end else begin
            wv <= wv_in;
            w  <= w_in;
            if (clr) begin
                acc <= '0;
                sat <= 1'b0;
            end else if (wv) begin
                acc <= acc_nx;
                sat <= sat | clamp;
            end
        end
    end
endmodule

// File: rtl/sa_col_ctrl.sv
// sa_col_ctrl: output-stationary systolic column with job sequencing and serial result drain.
// SA_COL_SAT_EN selects saturating PEs; sat_flags stays 0 when it is undefined.
module sa_col_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS   = ROWS_D,
    parameter int DATA_W = DATA_W_D,
    parameter int WGT_W  = WGT_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input logic          clk,
    input logic          rst_n,
    sa_col_ctrl_if.slave bus
);
    localparam int PW = $clog2(ROWS);
    state_t state, state_nx;
    logic [CNT_W-1:0] k_reg, cnt;
    logic [PW-1:0] fcnt, ptr;
    logic [ROWS*DATA_W-1:0] dout;
    logic done_q, clr, accept, hs, last;
    logic wv [ROWS+1];
    logic [WGT_W-1:0] wr [ROWS+1];
    logic [ACC_W-1:0] acc [ROWS];
    assign clr              = state == S_IDLE && bus.start;
    assign bus.w_ready      = state == S_ACCUM && cnt < k_reg;
    assign accept           = bus.w_valid && bus.w_ready;
    assign bus.res_valid    = state == S_DRAIN;
    assign hs               = bus.res_valid && bus.res_ready;
    assign last             = ptr == PW'(ROWS - 1);
    assign bus.res_last     = bus.res_valid && last;
    assign bus.res_data     = acc[ptr];
    assign bus.busy         = state != S_IDLE;
    assign bus.done         = done_q;
    assign bus.data_out     = dout;
    assign bus.w_valid_out  = wv[ROWS];
    assign bus.w_out        = wr[ROWS];
    assign wv[0]            = accept;
    assign wr[0]            = bus.w_in;
    for (genvar i = 0; i < ROWS; i++) begin : g_pe
        sa_pe_acc #(.DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .wv_in (wv[i]),
            .w_in  (wr[i]),
            .lane  (bus.data_in[i*DATA_W +: DATA_W]),
            .wv    (wv[i+1]),
            .w     (wr[i+1]),
            .acc   (acc[i]),
            .sat   (bus.sat_flags[i])
        );
        assign bus.result_bus[i*ACC_W +: ACC_W] = acc[i];
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nx = bus.k_len == '0 ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (accept && cnt + 1'b1 == k_reg) state_nx = S_FLUSH;
            // The last beat needs ROWS more edges to reach and accumulate in row ROWS-1.
            S_FLUSH: if (fcnt == PW'(ROWS - 1)) state_nx = S_DRAIN;
            S_DRAIN: if (hs && last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            k_reg  <= '0;
            cnt    <= '0;
            fcnt   <= '0;
            ptr    <= '0;
            done_q <= 1'b0;
            dout   <= '0;
        end else begin
            state  <= state_nx;
            done_q <= state == S_DRAIN && hs && last;
            dout   <= bus.data_in;
            k_reg  <= clr ? bus.k_len : k_reg;
            cnt    <= clr ? '0 : accept ? cnt + 1'b1 : cnt;
            fcnt   <= state == S_FLUSH ? fcnt + 1'b1 : '0;
            ptr    <= state != S_DRAIN ? '0 : hs ? ptr + 1'b1 : ptr;
        end
    end
endmodule

// File: tb/tb_sa_col_ctrl.sv
// tb_sa_col_ctrl: randomized jobs checked against a per-beat reference model of the column.
// Honours SA_COL_SAT_EN to expect saturating or wrapping accumulators.
module tb_sa_col_ctrl;
    localparam int ROWS = 4, DATA_W = 8, WGT_W = 8, ACC_W = 16, CNT_W = 16, N = 4096;
    typedef struct {int e; logic signed [WGT_W-1:0] w;} beat_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    sa_col_ctrl_if #(.ROWS(ROWS), .DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
    sa_col_ctrl #(.ROWS(ROWS), .DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    int vecs = 0, errs = 0, ecount = 0;
    int lane_mode = 0, lane_val = 0;
    logic [ROWS*DATA_W-1:0] hist [N];
    logic bv [N];
    logic [WGT_W-1:0] bw [N];
    beat_t beats[$];
    logic [ACC_W-1:0] exp_bits [ROWS];
    logic [ROWS-1:0] exp_sat;
    // hist[e] is data_in as sampled by rising edge number e.
    always @(posedge clk) begin
        hist[ecount % N] = bus.data_in;
        ecount++;
    end
    task automatic tick();
        @(negedge clk);
        for (int r = 0; r < ROWS; r++)
            bus.data_in[r*DATA_W +: DATA_W] = lane_mode != 0 ? DATA_W'(lane_val) : DATA_W'($urandom);
        bv[ecount % N] = 1'b0;
    endtask
    function automatic longint lane(input int e, input int r);
        logic [ROWS*DATA_W-1:0] v;
        logic signed [DATA_W-1:0] l;
        v = hist[e % N];
        l = v[r*DATA_W +: DATA_W];
        return longint'(l);
    endfunction
    // Beat j meets lane r on edge e_j+1+r; accumulate in beat order with wrap or clamp.
    task automatic compute_model();
        longint a, s, t;
        longint maxv, minv;
        logic [63:0] sb;
        logic signed [ACC_W-1:0] wrapped;
        maxv = (longint'(1) <<< (ACC_W - 1)) - 1;
        minv = -maxv - 1;
        for (int r = 0; r < ROWS; r++) begin
            a = 0;
            exp_sat[r] = 1'b0;
            foreach (beats[j]) begin
                t = lane(beats[j].e + 1 + r, r);
                s = a + t * longint'(beats[j].w);
`ifdef SA_COL_SAT_EN
                if (s > maxv) begin s = maxv; exp_sat[r] = 1'b1; end
                else if (s < minv) begin s = minv; exp_sat[r] = 1'b1; end
`else
                sb = s;
                wrapped = sb[ACC_W-1:0];
                s = longint'(wrapped);
`endif
                a = s;
            end
            sb = a;
            exp_bits[r] = sb[ACC_W-1:0];
        end
    endtask
    task automatic run_job(input int k, input int bub, input int stall, input int wmode, input bit start_in_drain, input int hold_len);
        int got, fl, guard, row, hold;
        bit sent;
        logic [ROWS*ACC_W-1:0] rb;
        beats.delete();
        tick();
        bus.start = 1'b1; bus.k_len = CNT_W'(k); bus.w_valid = 1'b0; bus.res_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        vecs++;
        if (bus.busy !== 1'b1) begin errs++; $display("FAIL busy_after_start got=%b want=1", bus.busy); end
        got = 0; fl = 0; guard = 0;
        while (k > 0 && (got < k || fl < ROWS) && guard < 8 * k + 40) begin
            vecs++;
            if (bus.w_ready !== (got < k) || bus.res_valid !== 1'b0)
                begin errs++; $display("FAIL accum_flush w_ready=%b res_valid=%b want %b/0 got=%0d", bus.w_ready, bus.res_valid, got < k, got); end
            vecs++;
            if (bus.data_out !== hist[(ecount - 1) % N] || bus.w_valid_out !== bv[(ecount - ROWS) % N] ||
                (bv[(ecount - ROWS) % N] && bus.w_out !== bw[(ecount - ROWS) % N]))
                begin errs++; $display("FAIL pipe data_out=%h wvo=%b w_out=%h want %h/%b/%h", bus.data_out, bus.w_valid_out, bus.w_out,
                    hist[(ecount - 1) % N], bv[(ecount - ROWS) % N], bw[(ecount - ROWS) % N]); end
            bus.w_valid = $urandom_range(99) >= bub;
            bus.w_in = wmode == 1 ? WGT_W'(got + 1) : wmode == 2 ? WGT_W'(127) : WGT_W'($urandom);
            if (got < k && bus.w_valid) begin
                beats.push_back('{e: ecount, w: bus.w_in});
                bv[ecount % N] = 1'b1;
                bw[ecount % N] = bus.w_in;
                got++;
            end else if (got >= k) fl++;
            tick();
            guard++;
        end
        bus.w_valid = 1'b0;
        compute_model();
        for (int r = 0; r < ROWS; r++) rb[r*ACC_W +: ACC_W] = exp_bits[r];
        row = 0; guard = 0; hold = 0; sent = 1'b0;
        while (row < ROWS && guard < 300) begin
            vecs++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp_bits[row] || bus.res_last !== (row == ROWS - 1) || bus.busy !== 1'b1 || bus.done !== 1'b0)
                begin errs++; $display("FAIL drain row=%0d valid=%b data=%h last=%b busy=%b done=%b want 1/%h/%b/1/0",
                    row, bus.res_valid, bus.res_data, bus.res_last, bus.busy, bus.done, exp_bits[row], row == ROWS - 1); end
            vecs++;
            if (bus.result_bus !== rb || bus.sat_flags !== exp_sat || bus.data_out !== hist[(ecount - 1) % N])
                begin errs++; $display("FAIL drain_bus result_bus=%h sat=%b data_out=%h want %h/%b/%h",
                    bus.result_bus, bus.sat_flags, bus.data_out, rb, exp_sat, hist[(ecount - 1) % N]); end
            bus.res_ready = $urandom_range(99) >= stall;
            if (row == 2 && hold < hold_len) begin bus.res_ready = 1'b0; hold++; end
            bus.start = start_in_drain && row == 1 && !sent;
            if (bus.start) begin sent = 1'b1; bus.k_len = CNT_W'(5); bus.res_ready = 1'b0; end
            if (bus.res_ready) row++;
            tick();
            guard++;
        end
        bus.start = 1'b0; bus.res_ready = 1'b0;
        vecs++;
        if (row < ROWS) begin errs++; $display("FAIL drain_timeout rows=%0d want %0d", row, ROWS); end
        vecs++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0)
            begin errs++; $display("FAIL done_pulse done=%b busy=%b res_valid=%b want 1/0/0", bus.done, bus.busy, bus.res_valid); end
        tick();
        vecs++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result_bus !== rb)
            begin errs++; $display("FAIL after_done done=%b busy=%b result_bus=%h want 0/0/%h", bus.done, bus.busy, bus.result_bus, rb); end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vecs++;
        if ({bus.busy, bus.done, bus.w_ready, bus.res_valid, bus.res_last, bus.w_valid_out, bus.res_data, bus.w_out, bus.data_out, bus.result_bus, bus.sat_flags} !== '0)
            begin errs++; $display("FAIL reset_outputs busy=%b done=%b res_data=%h data_out=%h result_bus=%h want all 0",
                bus.busy, bus.done, bus.res_data, bus.data_out, bus.result_bus); end
        rst_n = 1'b1;
        repeat (ROWS + 1) tick();
        vecs++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin errs++; $display("FAIL reset_idle busy=%b res_valid=%b want 0/0", bus.busy, bus.res_valid); end
    endtask
    task automatic test_basic();
        lane_mode = 1; lane_val = 2;
        run_job(3, 0, 0, 1, 1'b0, 0);
        vecs++;
        if (bus.result_bus !== {ROWS{16'd12}}) begin errs++; $display("FAIL basic_12 got=%h want %h", bus.result_bus, {ROWS{16'd12}}); end
    endtask
    task automatic test_bubbles();
        lane_mode = 1; lane_val = 2;
        run_job(3, 50, 0, 1, 1'b0, 0);
        vecs++;
        if (bus.result_bus !== {ROWS{16'd12}}) begin errs++; $display("FAIL bubbles_12 got=%h want %h", bus.result_bus, {ROWS{16'd12}}); end
    endtask
    task automatic test_stall();
        lane_mode = 0;
        run_job(3, 0, 0, 0, 1'b0, 5);
    endtask
    task automatic test_k_zero();
        lane_mode = 0;
        run_job(0, 0, 0, 0, 1'b1, 0);
        vecs++;
        if (bus.result_bus !== '0 || bus.busy !== 1'b0) begin errs++; $display("FAIL kzero result_bus=%h busy=%b want 0/0", bus.result_bus, bus.busy); end
    endtask
    task automatic test_reset_mid_job();
        lane_mode = 0;
        tick();
        bus.start = 1'b1; bus.k_len = CNT_W'(6);
        tick();
        bus.start = 1'b0;
        repeat (2) begin bus.w_valid = 1'b1; bus.w_in = WGT_W'($urandom); tick(); end
        bus.w_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({bus.busy, bus.done, bus.w_ready, bus.res_valid, bus.res_last, bus.w_valid_out, bus.res_data, bus.w_out, bus.data_out, bus.result_bus, bus.sat_flags} !== '0)
            begin errs++; $display("FAIL midjob_reset busy=%b w_ready=%b data_out=%h w_out=%h result_bus=%h want all 0",
                bus.busy, bus.w_ready, bus.data_out, bus.w_out, bus.result_bus); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (ROWS + 1) tick();
        run_job(3, 20, 20, 0, 1'b0, 0);
    endtask
    task automatic test_random();
        lane_mode = 0;
        repeat (6) run_job($urandom_range(12, 1), 30, 30, 0, 1'b0, 0);
    endtask
    task automatic test_wrap();
        lane_mode = 1; lane_val = 127;
        run_job(300, 0, 0, 2, 1'b0, 0);
        vecs++;
`ifdef SA_COL_SAT_EN
        if (bus.result_bus !== {ROWS{16'd32767}} || bus.sat_flags !== 4'hF)
            begin errs++; $display("FAIL saturate got=%h sat=%b want %h/1111", bus.result_bus, bus.sat_flags, {ROWS{16'd32767}}); end
`else
        if (bus.result_bus !== {ROWS{16'd54572}} || bus.sat_flags !== 4'h0)
            begin errs++; $display("FAIL wrap got=%h sat=%b want %h/0000", bus.result_bus, bus.sat_flags, {ROWS{16'd54572}}); end
`endif
    endtask
    initial begin
        bus.start = 1'b0; bus.k_len = '0; bus.w_valid = 1'b0; bus.w_in = '0; bus.data_in = '0; bus.res_ready = 1'b0;
        for (int i = 0; i < N; i++) bv[i] = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_stall();
        test_k_zero();
        test_reset_mid_job();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
